// File: rtl/npu_sram_dp.sv
// rtl/npu_sram_dp.sv - true dual-port SRAM with Avalon-MM slaves, reset clear sweep and byte-lane collision merge
module npu_sram_dp #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 14,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_WIDTH-1:0]     address,
  input  logic [DATA_WIDTH/8-1:0]   byteenable,
  input  logic                      chipselect,
  input  logic                      write,
  input  logic                      read,
  input  logic [DATA_WIDTH-1:0]     writedata,
  output logic [DATA_WIDTH-1:0]     readdata,
  output logic                      readdatavalid,
  output logic                      waitrequest,
  input  logic [ADDR_WIDTH-1:0]     address2,
  input  logic [DATA_WIDTH/8-1:0]   byteenable2,
  input  logic                      chipselect2,
  input  logic                      write2,
  input  logic                      read2,
  input  logic [DATA_WIDTH-1:0]     writedata2,
  output logic [DATA_WIDTH-1:0]     readdata2,
  output logic                      readdatavalid2,
  output logic                      waitrequest2,
  output logic                      init_done,
  output logic                      collision
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int DEPTH     = 1 << ADDR_WIDTH;

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("npu_sram_dp: READ_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("npu_sram_dp: DATA_WIDTH must be a multiple of 8");
  end

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   clr_addr;
  logic                    stall;

  logic [ADDR_WIDTH-1:0]   p_addr  [2];
  logic [NUM_BYTES-1:0]    p_be    [2];
  logic [DATA_WIDTH-1:0]   p_wdata [2];
  logic [1:0]              wr_acc;
  logic [1:0]              rd_acc;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [READ_LATENCY-1:0] pipe_vld  [2];
  logic [DATA_WIDTH-1:0]   pipe_data [2][READ_LATENCY];

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (clr_addr == '1) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      clr_addr  <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      init_done <= (state_nxt == RUN);
      if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
    end
  end

  assign stall        = (state == CLEAR);
  assign waitrequest  = stall;
  assign waitrequest2 = stall;

  assign p_addr[0]  = address;
  assign p_addr[1]  = address2;
  assign p_be[0]    = byteenable;
  assign p_be[1]    = byteenable2;
  assign p_wdata[0] = writedata;
  assign p_wdata[1] = writedata2;

  // read with write on the same port is treated as a write only
  assign wr_acc[0] = chipselect  & write  & ~stall;
  assign wr_acc[1] = chipselect2 & write2 & ~stall;
  assign rd_acc[0] = chipselect  & read   & ~write  & ~stall;
  assign rd_acc[1] = chipselect2 & read2  & ~write2 & ~stall;

  // s2 is applied first so that s1 overrides on lanes both ports enable
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_addr] <= '0;
    end else begin
      for (int p = 1; p >= 0; p--) begin
        if (wr_acc[p]) begin
          for (int b = 0; b < NUM_BYTES; b++) begin
            if (p_be[p][b]) mem[p_addr[p]][8*b +: 8] <= p_wdata[p][8*b +: 8];
          end
        end
      end
    end
  end

  // data stages only advance with a valid read so readdata holds between reads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      collision <= 1'b0;
      for (int p = 0; p < 2; p++) begin
        pipe_vld[p] <= '0;
        for (int s = 0; s < READ_LATENCY; s++) pipe_data[p][s] <= '0;
      end
    end else begin
      collision <= wr_acc[0] & wr_acc[1] & (address == address2) &
                   (|byteenable) & (|byteenable2);
      for (int p = 0; p < 2; p++) begin
        pipe_vld[p][0] <= rd_acc[p];
        if (rd_acc[p]) pipe_data[p][0] <= mem[p_addr[p]];
        for (int s = 1; s < READ_LATENCY; s++) begin
          pipe_vld[p][s] <= pipe_vld[p][s-1];
          if (pipe_vld[p][s-1]) pipe_data[p][s] <= pipe_data[p][s-1];
        end
      end
    end
  end

  assign readdata       = pipe_data[0][READ_LATENCY-1];
  assign readdatavalid  = pipe_vld[0][READ_LATENCY-1];
  assign readdata2      = pipe_data[1][READ_LATENCY-1];
  assign readdatavalid2 = pipe_vld[1][READ_LATENCY-1];

endmodule

// File: doc/npu_sram_dp.md
# npu_sram_dp

Parametrised true dual-port on-chip SRAM with two Avalon-MM slave ports (s1, s2) on one clock, for NPU weight and activation buffers in Computer_System. It adds configurable width, depth and read latency, plus readdatavalid/waitrequest handshakes. It clears the whole array to zero after reset and resolves same-address write collisions deterministically per byte lane.

## Interface
- DATA_WIDTH, 16: word width in bits; must be a multiple of 8. NUM_BYTES = DATA_WIDTH/8.
- ADDR_WIDTH, 14: word address width. DEPTH = 2^ADDR_WIDTH.
- READ_LATENCY, 1: 1 or 2 cycles from accepted read to readdatavalid. Other values are a compile-time error.
- CLEAR_ON_RESET, 1: when 1, a zero-fill sweep runs after reset. When 0, contents are undefined at power-up and left unchanged by reset.

Ports:
- clk  in  1  single clock for both ports.
- reset  in  1  asynchronous, active-high.
- address / address2  in  ADDR_WIDTH  word address for s1 / s2.
- byteenable / byteenable2  in  NUM_BYTES  write byte lanes.
- chipselect / chipselect2  in  1  port select.
- write / write2  in  1  write request.
- read / read2  in  1  read request.
- writedata / writedata2  in  DATA_WIDTH  write data.
- readdata / readdata2  out  DATA_WIDTH  read data.
- readdatavalid / readdatavalid2  out  1  readdata is valid this cycle.
- waitrequest / waitrequest2  out  1  port stalled; no request is accepted.
- init_done  out  1  high once the clear sweep has finished (or immediately after reset when CLEAR_ON_RESET=0).
- collision  out  1  one-cycle pulse when both ports accept a write to the same address.

## Operation
- FSM states: CLEAR, RUN.
  - Reset sends the FSM to CLEAR if CLEAR_ON_RESET=1, otherwise to RUN.
  - In CLEAR, clr_addr counts 0 to DEPTH-1 and writes all-zero, full-width, one word per cycle.
  - After writing DEPTH-1, the FSM goes to RUN. It stays in RUN until reset.
- In CLEAR, waitrequest and waitrequest2 are 1, and all port requests are ignored. In RUN, both are 0; the block never backpressures.
- Request acceptance:
  - A write is accepted when chipselect & write & ~waitrequest.
  - A read is accepted when chipselect & read & ~write & ~waitrequest.
  - write and read together on one port count as a write. No readdatavalid is produced for that cycle.
- Write: only lanes with byteenable[i]=1 update bits [8i+7:8i]. byteenable=0 is a no-op, and collision is not asserted for it.
- Read data is the array state before any write in the same cycle (old-data semantics). This holds for same-port and cross-port access.
- Dual write to the same address:
  - Lanes enabled on s1 take s1 data.
  - Lanes enabled only on s2 take s2 data.
  - Lanes enabled on neither are unchanged.
  - collision pulses the next cycle.
- Different-address dual writes and any mix of reads complete independently and in the same cycle.
- Reset asserted mid-CLEAR or mid-RUN:
  - The read pipeline is flushed; in-flight reads produce no readdatavalid.
  - The FSM restarts. With CLEAR_ON_RESET=1, the sweep restarts from address 0.
- Array storage is not reset directly; only the sweep clears it.

## Timing
- Reset values:
  - readdata = 0, readdatavalid = 0, collision = 0, init_done = 0 on both ports.
  - waitrequest = 1 (CLEAR_ON_RESET=1) or 0 (CLEAR_ON_RESET=0).
- Clear sweep: the first rising edge after reset deassertion writes address 0, and sweep write k occurs on edge k. After DEPTH edges, waitrequest falls and init_done rises together, on the edge after the final write.
- Read latency: a read accepted on edge T gives readdatavalid=1 with data on edge T+READ_LATENCY, for exactly one cycle.
  - Back-to-back reads are fully pipelined, one per cycle per port.
  - readdata holds its last valid value while readdatavalid=0.
- Writes take effect on the accepting edge. A read of the same address accepted on T+1 or later returns the new data.
- collision is registered: it is high for the single cycle after the accepting edge.

## Test plan
- Clear (ADDR_WIDTH=4, CLEAR_ON_RESET=1): preload the array with 0xFFFF, then pulse reset.
  - Required: waitrequest high for exactly 16 cycles, init_done rises at cycle 16.
  - Required: reads of all 16 addresses return 0x0000.
- Byte enables (defaults): on s1, write 0xABCD to 0x0010 with byteenable=11. Then write 0x1200 with byteenable=10.
  - Required: a read at 0x0010 returns 0x12CD, with readdatavalid exactly 1 cycle after acceptance.
- Collision: at 0x0100, s1 writes 0x1111 with be=01 and s2 writes 0x2222 with be=11 in the same cycle.
  - Required: the word reads 0x2211, and collision pulses one cycle.
- Read-during-write (0x0200 holds 0x5555): in one cycle, s1 writes 0x7777 to 0x0200 and s2 reads 0x0200.
  - Required: s2 returns 0x5555; an s2 read on the next cycle returns 0x7777.
- Pipelined reads (READ_LATENCY=2): issue 8 back-to-back s2 reads of addresses 0..7, preloaded with value = address.
  - Required: readdatavalid2 is high for 8 consecutive cycles starting 2 cycles after the first acceptance, with data 0..7 in order.
- Reset mid-operation: assert reset with 2 reads in flight and during clear address 5.
  - Required: no readdatavalid after reset.
  - Required: after deassertion, the sweep restarts at address 0 and takes the full DEPTH cycles.
